// File: rtl/bs_pkg.sv
// Shared encodings for the Black-Scholes job controller.
// Holds state/status codes, host command codes and their widths.
package bs_pkg;

    localparam int unsigned STATUS_W = 4;
    localparam int unsigned CMD_W    = 4;

    // State register value is exported directly as host status.
    typedef enum logic [STATUS_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_RUNNING  = 4'd1,
        ST_COMPLETE = 4'd2,
        ST_ERROR    = 4'd3
    } state_e;

    // Host commands; any other value behaves as NOP.
    typedef enum logic [CMD_W-1:0] {
        CMD_NOP   = 4'd0,
        CMD_RUN   = 4'd1,
        CMD_ACK   = 4'd2,
        CMD_ABORT = 4'd3
    } cmd_e;

endpackage

// File: rtl/bs_job_ctrl_if.sv
// Controller <-> BS compute engine link.
//   eng_start    : one-cycle launch pulse (controller -> engine)
//   eng_abort    : one-cycle cancel pulse (controller -> engine)
//   eng_operands : snapshotted constants (controller -> engine)
//   eng_done     : completion strobe (engine -> controller)
//   eng_result   : result, valid with eng_done (engine -> controller)
interface bs_job_ctrl_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_CONST = 4
) ();

    logic                       eng_start;
    logic                       eng_abort;
    logic [NUM_CONST*WIDTH-1:0] eng_operands;
    logic                       eng_done;
    logic [WIDTH-1:0]           eng_result;

    modport master (
        output eng_start,
        output eng_abort,
        output eng_operands,
        input  eng_done,
        input  eng_result
    );

    modport slave (
        input  eng_start,
        input  eng_abort,
        input  eng_operands,
        output eng_done,
        output eng_result
    );

endinterface

// File: rtl/bs_job_timer.sv
// Job latency counter with terminal-count detect.
//   clr   : load 1 (the next cycle is the first RUNNING cycle)
//   en    : increment
//   count : current RUNNING cycle number
//   hit_c : count has reached TIMEOUT
module bs_job_timer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             hit_c
);

    // Clear loads 1 so count equals the RUNNING cycle index.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (clr) begin
            count <= CNT_W'(1);
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit_c = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/bs_job_ctrl.sv
// Command-driven job controller for the BS compute engine.
//   cmd      : host command (NOP/RUN/ACK/ABORT), level-sampled
//   const_in : packed operand constants, snapshotted on RUN
//   status   : current state (IDLE/RUNNING/COMPLETE/ERROR)
//   dout     : captured engine result
//   cycles   : latency of last job in RUNNING cycles
//   eng      : engine link (start/abort pulses, operands, done/result)
module bs_job_ctrl
    import bs_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_CONST = 4,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [CMD_W-1:0]           cmd,
    input  logic [NUM_CONST*WIDTH-1:0] const_in,
    output logic [STATUS_W-1:0]        status,
    output logic [WIDTH-1:0]           dout,
    output logic [CNT_W-1:0]           cycles,
    bs_job_ctrl_if.master              eng
);

    state_e           state;
    logic [CNT_W-1:0] count;
    logic             hit_c;
    logic             launch_c;
    logic             count_en_c;

    assign launch_c   = (state == ST_IDLE) && (cmd == CMD_RUN);
    // Advance only when RUNNING continues past this cycle.
    assign count_en_c = (state == ST_RUNNING) && !eng.eng_done
                        && (cmd != CMD_ABORT) && !hit_c;

    bs_job_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .nreset (nreset),
        .clr    (launch_c),
        .en     (count_en_c),
        .count  (count),
        .hit_c  (hit_c)
    );

    // Job FSM with registered pulses, snapshot and result capture.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state            <= ST_IDLE;
            dout             <= '0;
            cycles           <= '0;
            eng.eng_start    <= 1'b0;
            eng.eng_abort    <= 1'b0;
            eng.eng_operands <= '0;
        end else begin
            eng.eng_start <= 1'b0;
            eng.eng_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd == CMD_RUN) begin
                        eng.eng_operands <= const_in;
                        eng.eng_start    <= 1'b1;
                        state            <= ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    // done > abort > timeout
                    if (eng.eng_done) begin
                        dout   <= eng.eng_result;
                        cycles <= count;
                        state  <= ST_COMPLETE;
                    end else if (cmd == CMD_ABORT) begin
                        eng.eng_abort <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (hit_c) begin
                        cycles <= count;
                        state  <= ST_ERROR;
                    end
                end
                ST_COMPLETE, ST_ERROR: begin
                    if (cmd == CMD_ACK) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign status = state;

endmodule
